// File: rtl/map_table.sv
// Register rename map table for the dispatch stage.
// Holds one {physical tag, ready} entry per architectural register.
// Lookup of every dispatching source is purely combinational. The table
// is updated on the rising clock edge: completions set ready bits first,
// then renames of valid destinations overwrite entries.

package map_table_pkg;
  localparam int N_WAY     = 3;
  localparam int N_ARCH    = 32;
  localparam int ARCH_BITS = 5;
  localparam int CDB_BITS  = 6;

  typedef struct packed {
    logic                 valid;
    logic [ARCH_BITS-1:0] src1;
    logic [ARCH_BITS-1:0] src2;
    logic [ARCH_BITS-1:0] dest;
  } DISPATCH_ROB_PACKET;

  typedef struct packed {
    logic [CDB_BITS-1:0] pr;
    logic                ready;
  } PR_PACKET;
endpackage

module map_table
  import map_table_pkg::*;
(
  input  logic                               clock,
  input  logic                               reset,
  input  DISPATCH_ROB_PACKET [N_WAY-1:0]     dis_packet,
  input  logic [N_WAY-1:0][CDB_BITS-1:0]     pr_freelist,
  input  logic [N_WAY-1:0][CDB_BITS-1:0]     pr_reg_complete,
  output PR_PACKET [N_WAY-1:0]               pr_packet_out1,
  output PR_PACKET [N_WAY-1:0]               pr_packet_out2
);

  // Architectural state: one entry per architectural register.
  PR_PACKET table_q [N_ARCH];
  PR_PACKET table_d [N_ARCH];

  // True when a physical tag is announced complete on the CDB this cycle.
  // Tag 0 on a CDB lane means "no completion" and never matches.
  function automatic logic tag_completed(input logic [CDB_BITS-1:0] tag);
    logic hit;
    hit = 1'b0;
    for (int m = 0; m < N_WAY; m++) begin
      if ((pr_reg_complete[m] != '0) && (pr_reg_complete[m] == tag)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // Resolve one source operand of way k.
  // Order: table read, intra-group forwarding from older ways (the youngest
  // older writer wins because later iterations overwrite), completion
  // bypass on the resolved tag, and finally the hard-wired x0 mapping.
  // While reset is held, only the identity table is shown.
  function automatic PR_PACKET resolve(input int k,
                                       input logic [ARCH_BITS-1:0] src);
    PR_PACKET res;
    res = table_q[src];
    if (!reset) begin
      for (int j = 0; j < N_WAY; j++) begin
        if ((j < k) && dis_packet[j].valid &&
            (dis_packet[j].dest != '0) && (dis_packet[j].dest == src)) begin
          res.pr    = pr_freelist[j];
          res.ready = 1'b0;
        end
      end
      if (tag_completed(res.pr)) begin
        res.ready = 1'b1;
      end
    end
    if (src == '0) begin
      res.pr    = '0;
      res.ready = 1'b1;
    end
    return res;
  endfunction

  // Combinational lookup of both sources for every dispatch way.
  always_comb begin
    pr_packet_out1 = '0;
    pr_packet_out2 = '0;
    for (int k = 0; k < N_WAY; k++) begin
      pr_packet_out1[k] = resolve(k, dis_packet[k].src1);
      pr_packet_out2[k] = resolve(k, dis_packet[k].src2);
    end
  end

  // Next-state table: apply completions, then renames (highest way wins,
  // and a rename replaces any ready bit set by a completion this cycle).
  always_comb begin
    for (int i = 0; i < N_ARCH; i++) begin
      table_d[i] = table_q[i];
      if (tag_completed(table_q[i].pr)) begin
        table_d[i].ready = 1'b1;
      end
    end
    for (int k = 0; k < N_WAY; k++) begin
      if (dis_packet[k].valid && (dis_packet[k].dest != '0)) begin
        table_d[dis_packet[k].dest].pr    = pr_freelist[k];
        table_d[dis_packet[k].dest].ready = 1'b0;
      end
    end
  end

  // Table register; reset restores the identity map with all entries ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_ARCH; i++) begin
        table_q[i].pr    <= CDB_BITS'(i);
        table_q[i].ready <= 1'b1;
      end
    end else begin
      for (int i = 0; i < N_ARCH; i++) begin
        table_q[i] <= table_d[i];
      end
    end
  end

endmodule

// File: tb/tb_map_table.sv
// Testbench for map_table: directed scenarios followed by random traffic,
// all compared against a register-file level model of the rename rules.

module tb_map_table;
  import map_table_pkg::*;

  logic clock;
  logic reset;
  DISPATCH_ROB_PACKET [N_WAY-1:0]  dis_packet;
  logic [N_WAY-1:0][CDB_BITS-1:0]  pr_freelist;
  logic [N_WAY-1:0][CDB_BITS-1:0]  pr_reg_complete;
  PR_PACKET [N_WAY-1:0]            pr_packet_out1;
  PR_PACKET [N_WAY-1:0]            pr_packet_out2;

  map_table dut (
    .clock           (clock),
    .reset           (reset),
    .dis_packet      (dis_packet),
    .pr_freelist     (pr_freelist),
    .pr_reg_complete (pr_reg_complete),
    .pr_packet_out1  (pr_packet_out1),
    .pr_packet_out2  (pr_packet_out2)
  );

  // Clock: period 10, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Stimulus arrays (bench-side view of the dispatch group)
  logic       s_v  [N_WAY];
  logic [4:0] s_s1 [N_WAY];
  logic [4:0] s_s2 [N_WAY];
  logic [4:0] s_d  [N_WAY];
  logic [5:0] s_fl [N_WAY];
  logic [5:0] s_cm [N_WAY];

  // Reference model: architectural register -> {tag, ready}
  int m_pr  [32];
  bit m_rdy [32];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_pr[i]  = i;
      m_rdy[i] = 1'b1;
    end
  endtask

  // Expected mapping of a source for way k, from the rename rules.
  function automatic logic [6:0] exp_lookup(int k, logic [4:0] src);
    logic [5:0] pr;
    logic       rdy;
    if (src == 5'd0) return {6'd0, 1'b1};
    pr  = 6'(m_pr[src]);
    rdy = m_rdy[src];
    for (int j = k - 1; j >= 0; j--) begin
      if (s_v[j] && s_d[j] == src) begin
        pr  = s_fl[j];
        rdy = 1'b0;
        break;
      end
    end
    for (int m = 0; m < N_WAY; m++)
      if (s_cm[m] != 6'd0 && s_cm[m] == pr) rdy = 1'b1;
    return {pr, rdy};
  endfunction

  // Clock-edge effect on the model: completions, then renames in way order.
  task automatic model_edge();
    for (int i = 0; i < 32; i++)
      for (int m = 0; m < N_WAY; m++)
        if (s_cm[m] != 6'd0 && 6'(m_pr[i]) == s_cm[m]) m_rdy[i] = 1'b1;
    for (int k = 0; k < N_WAY; k++) begin
      if (s_v[k] && s_d[k] != 5'd0) begin
        m_pr[s_d[k]]  = s_fl[k];
        m_rdy[s_d[k]] = 1'b0;
      end
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N_WAY; k++) begin
      dis_packet[k].valid = s_v[k];
      dis_packet[k].src1  = s_s1[k];
      dis_packet[k].src2  = s_s2[k];
      dis_packet[k].dest  = s_d[k];
      pr_freelist[k]      = s_fl[k];
      pr_reg_complete[k]  = s_cm[k];
    end
  endtask

  task automatic clear_stim();
    for (int k = 0; k < N_WAY; k++) begin
      s_v[k] = 1'b0; s_s1[k] = 5'd0; s_s2[k] = 5'd0; s_d[k] = 5'd0;
      s_fl[k] = 6'd0; s_cm[k] = 6'd0;
    end
  endtask

  task automatic chk(string tag, logic [6:0] obs, logic [6:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed pr=%0d rdy=%0b expected pr=%0d rdy=%0b",
             tag, obs[6:1], obs[0], exp_v[6:1], exp_v[0]);
    end
  endtask

  function automatic logic [6:0] o1(int k);
    logic [6:0] r;
    r = pr_packet_out1[k];
    return r;
  endfunction

  function automatic logic [6:0] o2(int k);
    logic [6:0] r;
    r = pr_packet_out2[k];
    return r;
  endfunction

  // Check all outputs against the model at the falling edge, then advance
  // the model across the rising edge. Entered and left at posedge+1.
  task automatic cycle(string tag);
    @(negedge clock);
    for (int k = 0; k < N_WAY; k++) begin
      chk($sformatf("%s_w%0d_src1", tag, k), o1(k), exp_lookup(k, s_s1[k]));
      chk($sformatf("%s_w%0d_src2", tag, k), o2(k), exp_lookup(k, s_s2[k]));
    end
    @(posedge clock);
    model_edge();
    #1;
  endtask

  // Look up two registers with nothing dispatching, against fixed values.
  task automatic query(string tag, logic [4:0] a, logic [6:0] ea,
                       logic [4:0] b, logic [6:0] eb);
    clear_stim();
    s_s1[0] = a; s_s2[0] = b;
    drive();
    #1;
    chk({tag, "_a"}, o1(0), ea);
    chk({tag, "_b"}, o2(0), eb);
    cycle(tag);
  endtask

  task automatic set_way(int k, logic v, logic [4:0] a, logic [4:0] b,
                         logic [4:0] d, logic [5:0] fl);
    s_v[k] = v; s_s1[k] = a; s_s2[k] = b; s_d[k] = d; s_fl[k] = fl;
  endtask

  initial begin
    // Reset with all sources at x0
    reset = 1'b1;
    clear_stim();
    drive();
    model_reset();
    #1;
    for (int k = 0; k < N_WAY; k++) begin
      chk($sformatf("rst_w%0d_src1", k), o1(k), {6'd0, 1'b1});
      chk($sformatf("rst_w%0d_src2", k), o2(k), {6'd0, 1'b1});
    end
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    query("post_rst", 5'd5, {6'd5, 1'b1}, 5'd31, {6'd31, 1'b1});

    // Cycle A
    clear_stim();
    set_way(0, 1'b1, 5'd0, 5'd1, 5'd2, 6'd33);
    set_way(1, 1'b1, 5'd3, 5'd4, 5'd5, 6'd34);
    set_way(2, 1'b1, 5'd6, 5'd7, 5'd8, 6'd35);
    drive(); #1;
    chk("A_w0_1", o1(0), {6'd0, 1'b1}); chk("A_w0_2", o2(0), {6'd1, 1'b1});
    chk("A_w1_1", o1(1), {6'd3, 1'b1}); chk("A_w1_2", o2(1), {6'd4, 1'b1});
    chk("A_w2_1", o1(2), {6'd6, 1'b1}); chk("A_w2_2", o2(2), {6'd7, 1'b1});
    cycle("A");
    query("A_r2r5", 5'd2, {6'd33, 1'b0}, 5'd5, {6'd34, 1'b0});
    query("A_r8", 5'd8, {6'd35, 1'b0}, 5'd0, {6'd0, 1'b1});

    // Cycle B: intra-group forwarding
    clear_stim();
    set_way(0, 1'b1, 5'd1, 5'd2, 5'd3, 6'd36);
    set_way(1, 1'b1, 5'd3, 5'd4, 5'd5, 6'd37);
    set_way(2, 1'b1, 5'd7, 5'd5, 5'd8, 6'd38);
    drive(); #1;
    chk("B_w0_1", o1(0), {6'd1, 1'b1});  chk("B_w0_2", o2(0), {6'd33, 1'b0});
    chk("B_w1_1", o1(1), {6'd36, 1'b0}); chk("B_w1_2", o2(1), {6'd4, 1'b1});
    chk("B_w2_1", o1(2), {6'd7, 1'b1});  chk("B_w2_2", o2(2), {6'd37, 1'b0});
    cycle("B");

    // Cycle C: completion bypass, stale tag, dest x0
    clear_stim();
    set_way(0, 1'b1, 5'd2, 5'd3, 5'd4, 6'd39);
    set_way(1, 1'b1, 5'd5, 5'd6, 5'd8, 6'd40);
    set_way(2, 1'b1, 5'd6, 5'd7, 5'd0, 6'd41);
    s_cm[0] = 6'd33; s_cm[1] = 6'd34; s_cm[2] = 6'd0;
    drive(); #1;
    chk("C_w0_1", o1(0), {6'd33, 1'b1}); chk("C_w0_2", o2(0), {6'd36, 1'b0});
    chk("C_w1_1", o1(1), {6'd37, 1'b0}); chk("C_w1_2", o2(1), {6'd6, 1'b1});
    chk("C_w2_1", o1(2), {6'd6, 1'b1});  chk("C_w2_2", o2(2), {6'd7, 1'b1});
    cycle("C");
    query("C_r2r4", 5'd2, {6'd33, 1'b1}, 5'd4, {6'd39, 1'b0});
    query("C_r8r0", 5'd8, {6'd40, 1'b0}, 5'd0, {6'd0, 1'b1});

    // Invalid group leaves the table unchanged
    clear_stim();
    set_way(0, 1'b0, 5'd1, 5'd1, 5'd8, 6'd60);
    set_way(1, 1'b0, 5'd8, 5'd3, 5'd3, 6'd61);
    set_way(2, 1'b0, 5'd3, 5'd8, 5'd1, 6'd62);
    drive(); #1;
    chk("inv_w1_1", o1(1), {6'd40, 1'b0});
    cycle("inv");
    query("inv_after", 5'd8, {6'd40, 1'b0}, 5'd3, {6'd36, 1'b0});

    // Same-destination collision, then asynchronous reset mid-cycle
    clear_stim();
    set_way(0, 1'b1, 5'd11, 5'd12, 5'd9, 6'd50);
    set_way(1, 1'b1, 5'd9, 5'd13, 5'd10, 6'd51);
    set_way(2, 1'b1, 5'd14, 5'd15, 5'd9, 6'd52);
    drive(); #1;
    chk("col_w1_1", o1(1), {6'd50, 1'b0});
    cycle("col");
    clear_stim();
    s_s1[0] = 5'd9; s_s2[0] = 5'd10;
    drive(); #1;
    chk("col_r9", o1(0), {6'd52, 1'b0});
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_r9", o1(0), {6'd9, 1'b1});
    chk("arst_r10", o2(0), {6'd10, 1'b1});
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < N_WAY; k++) begin
        s_v[k]  = ($urandom_range(0, 3) != 0);
        s_s1[k] = 5'($urandom_range(0, 15));
        s_s2[k] = 5'($urandom_range(0, 15));
        s_d[k]  = 5'($urandom_range(0, 15));
        s_fl[k] = 6'($urandom_range(32, 63));
        case ($urandom_range(0, 2))
          0: s_cm[k] = 6'd0;
          1: s_cm[k] = 6'(m_pr[$urandom_range(0, 15)]);
          default: s_cm[k] = 6'($urandom_range(0, 63));
        endcase
      end
      drive();
      #1;
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
